jt51_acc_mix: RTL and testbench

Parametrised frame accumulator/mixer for the FM operator pipeline. Each cen cycle it takes one slot's operator output. Slots flagged by the algorithm decoder are summed into separate left and right accumulators, gated by that slot's channel pan bits. At the end of each frame it applies a master attenuation shift, saturates to the DAC width, and presents a registered stereo sample with a strobe and sticky clip flags. It sits between the operator pipeline and the output DAC/filter stage.

---
 rtl/jt51_acc_mix_if.sv | 37 +++
 rtl/jt51_acc_mix.sv | 143 ++++++++++++++
 tb/tb_jt51_acc_mix.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/jt51_acc_mix_if.sv
// Bus interface for jt51_acc_mix.
// The master drives the per-slot operator stream and its controls. The slave returns the
// stereo sample, the sample strobe, the sticky clip flags and the current slot index.
//   cen, frame_start, op_in, sum_en, rl, shift, clr_clip : master -> slave
//   left, right, sample, clip_l, clip_r, slot            : slave -> master
interface jt51_acc_mix_if #(
  parameter int unsigned OPW   = 14,
  parameter int unsigned OUTW  = 16,
  parameter int unsigned SLOTS = 32,
  parameter int unsigned SHW   = 3
);
  localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic                   cen;
  logic                   frame_start;
  logic signed [OPW-1:0]  op_in;
  logic                   sum_en;
  logic [1:0]             rl;
  logic [SHW-1:0]         shift;
  logic                   clr_clip;
  logic signed [OUTW-1:0] left;
  logic signed [OUTW-1:0] right;
  logic                   sample;
  logic                   clip_l;
  logic                   clip_r;
  logic [SW-1:0]          slot;

  modport master (
    output cen, frame_start, op_in, sum_en, rl, shift, clr_clip,
    input  left, right, sample, clip_l, clip_r, slot
  );

  modport slave (
    input  cen, frame_start, op_in, sum_en, rl, shift, clr_clip,
    output left, right, sample, clip_l, clip_r, slot
  );
endinterface

// File: rtl/jt51_acc_mix.sv
// Frame accumulator / stereo mixer for the FM operator pipeline.
// One slot is consumed per cen cycle. Carrier slots (sum_en) are added into separate left and
// right accumulators, gated by the pan bits rl. On the last slot of a frame the sum (including
// that last slot) is shifted right arithmetically by shift, saturated to OUTW bits and
// registered onto left/right together with a one-clk sample strobe.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : jt51_acc_mix_if slave modport (operator stream in, stereo sample out)
module jt51_acc_mix #(
  parameter int unsigned OPW   = 14,
  parameter int unsigned ACCW  = 18,
  parameter int unsigned OUTW  = 16,
  parameter int unsigned SLOTS = 32,
  parameter int unsigned SHW   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  jt51_acc_mix_if.slave  bus
);
  localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SW-1:0] LastSlot = SW'(SLOTS - 1);

  localparam logic signed [ACCW-1:0] AccMax = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] AccMin = {1'b1, {(ACCW-1){1'b0}}};
  // OUTW limits, sign-extended to the accumulator width for comparison.
  localparam logic signed [ACCW-1:0] OutMax = ACCW'({1'b0, {(OUTW-1){1'b1}}});
  localparam logic signed [ACCW-1:0] OutMin = ~OutMax;

  function automatic logic signed [ACCW-1:0] sat_acc(input logic signed [ACCW:0] s);
    // Overflow shows as disagreement between the guard bit and the ACCW sign bit.
    if (s[ACCW] != s[ACCW-1]) return s[ACCW] ? AccMin : AccMax;
    return s[ACCW-1:0];
  endfunction

  function automatic logic signed [OUTW-1:0] sat_out(input logic signed [ACCW-1:0] g);
    if (g > OutMax) return OutMax[OUTW-1:0];
    if (g < OutMin) return OutMin[OUTW-1:0];
    return g[OUTW-1:0];
  endfunction

  logic signed [ACCW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [OUTW-1:0] left_q, left_d, right_q, right_d;
  logic                   sample_q, sample_d;
  logic                   clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic [SW-1:0]          slot_q, slot_d;
  logic                   locked_q, locked_d;

  logic [SW-1:0]          cur_slot;
  logic signed [ACCW-1:0] op_ext, c_l, c_r;
  logic signed [ACCW:0]   sum_l, sum_r;
  logic                   ovf_l, ovf_r;
  logic signed [ACCW-1:0] f_l, f_r, g_l, g_r;
  logic                   oclip_l, oclip_r;

  // Slot being processed this cen cycle.
  assign cur_slot = bus.frame_start ? '0 :
                    (slot_q == LastSlot) ? '0 : slot_q + SW'(1);

  assign op_ext = {{(ACCW-OPW){bus.op_in[OPW-1]}}, bus.op_in};
  assign c_l    = (bus.sum_en && bus.rl[0]) ? op_ext : '0;
  assign c_r    = (bus.sum_en && bus.rl[1]) ? op_ext : '0;

  // One guard bit so the accumulator overflow is detectable.
  assign sum_l = {acc_l_q[ACCW-1], acc_l_q} + {c_l[ACCW-1], c_l};
  assign sum_r = {acc_r_q[ACCW-1], acc_r_q} + {c_r[ACCW-1], c_r};
  assign ovf_l = sum_l[ACCW] ^ sum_l[ACCW-1];
  assign ovf_r = sum_r[ACCW] ^ sum_r[ACCW-1];
  assign f_l   = sat_acc(sum_l);
  assign f_r   = sat_acc(sum_r);

  assign g_l     = f_l >>> bus.shift;
  assign g_r     = f_r >>> bus.shift;
  assign oclip_l = (g_l > OutMax) || (g_l < OutMin);
  assign oclip_r = (g_r > OutMax) || (g_r < OutMin);

  always_comb begin
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    left_d   = left_q;
    right_d  = right_q;
    sample_d = 1'b0;
    slot_d   = slot_q;
    locked_d = locked_q;
    // Clear first so a same-cycle set below wins.
    clip_l_d = clip_l_q & ~bus.clr_clip;
    clip_r_d = clip_r_q & ~bus.clr_clip;

    if (bus.cen) begin
      slot_d = cur_slot;
      if (bus.frame_start) locked_d = 1'b1;

      if (cur_slot == '0) begin
        // Slot 0 restarts the frame; any partial frame is dropped.
        acc_l_d = c_l;
        acc_r_d = c_r;
      end else begin
        acc_l_d = f_l;
        acc_r_d = f_r;
        if (ovf_l) clip_l_d = 1'b1;
        if (ovf_r) clip_r_d = 1'b1;
      end

      if (cur_slot == LastSlot && locked_q) begin
        left_d   = sat_out(g_l);
        right_d  = sat_out(g_r);
        sample_d = 1'b1;
        if (oclip_l) clip_l_d = 1'b1;
        if (oclip_r) clip_r_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      slot_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      sample_q <= sample_d;
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
      slot_q   <= slot_d;
      locked_q <= locked_d;
    end
  end

  assign bus.left   = left_q;
  assign bus.right  = right_q;
  assign bus.sample = sample_q;
  assign bus.clip_l = clip_l_q;
  assign bus.clip_r = clip_r_q;
  assign bus.slot   = slot_q;
endmodule

// File: tb/tb_jt51_acc_mix.sv
// Directed bench for jt51_acc_mix: one cen slot every other clock, expected values hand-computed.
module tb_jt51_acc_mix;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  jt51_acc_mix_if #(.OPW(14), .OUTW(16), .SLOTS(32), .SHW(3)) bus ();

  jt51_acc_mix #(
    .OPW(14), .ACCW(18), .OUTW(16), .SLOTS(32), .SHW(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cen_cnt = 0;
  int n_samples = 0;
  int sample_at = -1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each clock with sample high is one negedge, so a stretched pulse counts twice.
  always @(negedge clk) begin
    if (bus.sample) begin
      n_samples++;
      sample_at = cen_cnt;
    end
  end

  // One cen clock followed by one idle clock.
  task automatic run_slot(input logic fs, input int op_val, input logic en, input logic [1:0] rl,
                          input logic clr);
    bus.cen         = 1'b1;
    bus.frame_start = fs;
    bus.op_in       = 14'(op_val);
    bus.sum_en      = en;
    bus.rl          = rl;
    bus.clr_clip    = clr;
    @(posedge clk);
    #1;
    cen_cnt++;
    bus.cen         = 1'b0;
    bus.frame_start = 1'b0;
    bus.sum_en      = 1'b0;
    bus.clr_clip    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Full frame: frame_start on slot 0; slot i pan = {rl_r[i], rl_l[i]}.
  task automatic run_frame(input int op_val, input logic [31:0] mask, input logic [31:0] rl_l,
                           input logic [31:0] rl_r, input int clr_at);
    for (int i = 0; i < 32; i++) begin
      run_slot(i == 0, op_val, mask[i], {rl_r[i], rl_l[i]}, i == clr_at);
    end
  endtask

  int base;
  int fs_cen;

  initial begin
    bus.cen         = 1'b0;
    bus.frame_start = 1'b0;
    bus.op_in       = '0;
    bus.sum_en      = 1'b0;
    bus.rl          = 2'b00;
    bus.shift       = '0;
    bus.clr_clip    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_left", bus.left, 0);
    chk("rst_right", bus.right, 0);
    chk("rst_sample", bus.sample, 0);
    chk("rst_clip_l", bus.clip_l, 0);
    chk("rst_clip_r", bus.clip_r, 0);
    chk("rst_slot", bus.slot, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Not locked yet: accumulation runs across a wrap but nothing is emitted.
    for (int i = 0; i < 40; i++) run_slot(1'b0, 1000, 1'b1, 2'b11, 1'b0);
    chk("unlocked_no_sample", n_samples, 0);

    // Slots 3,7,11,15 = 4096 left only -> 16384.
    base = n_samples;
    run_frame(4096, 32'h0000_8888, 32'hFFFF_FFFF, 32'h0, -1);
    chk("t1_samples", n_samples - base, 1);
    chk("t1_left", bus.left, 16384);
    chk("t1_right", bus.right, 0);
    chk("t1_clip_l", bus.clip_l, 0);
    chk("t1_clip_r", bus.clip_r, 0);
    chk("t1_slot", bus.slot, 31);
    chk("t1_sample_low", bus.sample, 0);

    // Slots 3,7 both sides, 11,15 right only, shift 2: L=8192>>2, R=16384>>2.
    bus.shift = 3'd2;
    base = n_samples;
    run_frame(4096, 32'h0000_8888, 32'h0000_0088, 32'h0000_8888, -1);
    chk("t2_samples", n_samples - base, 1);
    chk("t2_left", bus.left, 2048);
    chk("t2_right", bus.right, 4096);

    // 32 x 8191 clamps at 131071 -> 32767 on both sides, both clip flags set.
    bus.shift = 3'd0;
    base = n_samples;
    run_frame(8191, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("t3_samples", n_samples - base, 1);
    chk("t3_left", bus.left, 32767);
    chk("t3_right", bus.right, 32767);
    chk("t3_clip_l", bus.clip_l, 1);
    chk("t3_clip_r", bus.clip_r, 1);

    // Clean frame with clr_clip on slot 5.
    run_frame(0, 32'h0, 32'h0, 32'h0, 5);
    chk("clr_left", bus.left, 0);
    chk("clr_clip_l", bus.clip_l, 0);
    chk("clr_clip_r", bus.clip_r, 0);

    // 32 x -8192 left only clamps at -131072 -> -32768.
    base = n_samples;
    run_frame(-8192, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, -1);
    chk("t4_samples", n_samples - base, 1);
    chk("t4_left", bus.left, -32768);
    chk("t4_right", bus.right, 0);
    chk("t4_clip_l", bus.clip_l, 1);
    chk("t4_clip_r", bus.clip_r, 0);

    // Frame aborted at slot 20 by a new frame_start; only the new frame (32 x 100 left) counts.
    base = n_samples;
    for (int i = 0; i < 20; i++) run_slot(i == 0, 1000, 1'b1, 2'b11, 1'b0);
    chk("t5_abort_no_sample", n_samples - base, 0);
    fs_cen = cen_cnt + 1;
    for (int i = 0; i < 32; i++) run_slot(i == 0, 100, 1'b1, 2'b01, 1'b0);
    chk("t5_samples", n_samples - base, 1);
    // Sample follows the 32nd cen counting the frame_start one.
    chk("t5_sample_cen", sample_at, fs_cen + 31);
    chk("t5_left", bus.left, 3200);
    chk("t5_right", bus.right, 0);

    // Asynchronous reset mid-frame, away from any clock edge.
    for (int i = 0; i < 10; i++) run_slot(i == 0, 100, 1'b1, 2'b11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_left", bus.left, 0);
    chk("t6_rst_clip_l", bus.clip_l, 0);
    chk("t6_rst_slot", bus.slot, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = n_samples;
    for (int i = 0; i < 40; i++) run_slot(1'b0, 100, 1'b1, 2'b11, 1'b0);
    chk("t6_relock_no_sample", n_samples - base, 0);
    run_frame(10, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, -1);
    chk("t6_samples", n_samples - base, 1);
    chk("t6_left", bus.left, 0);
    chk("t6_right", bus.right, 320);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
